// File: rtl/bp_me_pkg.sv
// Shared definitions for the ME test-memory slice.
//   - LFSR seed and Fibonacci tap mask used by the backpressure injector
//   - in-flight response entry carried by the delay pipe and response queue
package bp_me_pkg;

  localparam int unsigned bp_block_width_gp = 512;

  localparam logic [15:0] lfsr_seed_gp = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] lfsr_taps_gp = 16'hB400;

  typedef struct packed {
    logic [bp_block_width_gp-1:0] data;
  } bp_mem_entry_s;

endpackage

// File: rtl/bp_mem_ram_delay_pipe.sv
// Fixed-latency valid+data shift pipe for in-flight memory responses.
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset (clears valids)
//   v_i, data_i       entry captured at this edge
//   v_o, data_o       entry latency_p edges after capture
module bp_mem_ram_delay_pipe
  import bp_me_pkg::*;
#(
  parameter int unsigned latency_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               v_i,
  input  logic [$bits(bp_mem_entry_s)-1:0]   data_i,
  output logic                               v_o,
  output logic [$bits(bp_mem_entry_s)-1:0]   data_o
);

  logic [latency_p-1:0] v_q;
  bp_mem_entry_s        data_q [latency_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q <= '0;
    end else begin
      v_q[0] <= v_i;
      for (int unsigned i = 1; i < latency_p; i++) v_q[i] <= v_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    data_q[0] <= data_i;
    for (int unsigned i = 1; i < latency_p; i++) data_q[i] <= data_q[i-1];
  end

  assign v_o    = v_q[latency_p-1];
  assign data_o = data_q[latency_p-1];

endmodule

// File: rtl/bp_mem_ram_fifo.sv
// Small two-port FIFO primitive (one push, one pop per cycle).
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   v_i, data_i       push side
//   full_o            no free slot
//   v_o, data_o       head valid / head data
//   yumi_i            pop head (ignored while empty)
module bp_mem_ram_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic                push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign push   = v_i;
  assign pop    = yumi_i & v_o;
  assign v_o    = (cnt_q != '0);
  assign full_o = (cnt_q == cnt_w_lp'(els_p));
  assign data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push && full_o));

endmodule

// File: rtl/bp_mem_latency_ram.sv
// Block-granular fixed-latency test memory behind the ME memory transducer.
// Requests are accepted on v_i & ready_o; each returns one full block, in
// order, no earlier than latency_p cycles after accept. Write responses and
// out-of-range reads return all zeros. At most outstanding_p requests are in
// flight between accept and yumi.
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   v_i, w_i, addr_i            request valid / write / block-aligned address
//   data_i, write_mask_i        write data / per-byte write enable
//   ready_o                     request may be accepted (registered state only)
//   v_o, data_o, yumi_i         response valid / data / consumed
// Build option:
//   BP_MEM_LATENCY_RAM_BACKPRESSURE_EN  adds a 16-bit LFSR that forces ready_o
//                                       low when lfsr[1:0]==0
module bp_mem_latency_ram
  import bp_me_pkg::*;
#(
  parameter int unsigned block_width_p = bp_block_width_gp,
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned els_p         = 1024,
  parameter int unsigned latency_p     = 4,
  parameter int unsigned outstanding_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic                       w_i,
  input  logic [paddr_width_p-1:0]   addr_i,
  input  logic [block_width_p-1:0]   data_i,
  input  logic [block_width_p/8-1:0] write_mask_i,
  output logic                       ready_o,
  output logic [block_width_p-1:0]   data_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  localparam int unsigned mask_w_lp = block_width_p / 8;
  localparam int unsigned offset_lp = $clog2(mask_w_lp);
  localparam int unsigned idx_w_lp  = $clog2(els_p);
  localparam int unsigned cnt_w_lp  = $clog2(outstanding_p + 1);
  localparam int unsigned entry_w_lp = $bits(bp_mem_entry_s);

  logic [block_width_p-1:0] mem_q [els_p];
  logic [paddr_width_p-1:0] idx;
  logic [idx_w_lp-1:0]      mem_idx;
  logic                     in_range, accept, pop, stall;
  logic [cnt_w_lp-1:0]      count_q, count_d;
  logic                     ready_en_q;
  bp_mem_entry_s            req_entry, pipe_entry, head_entry;
  logic                     pipe_v, fifo_v, fifo_full;

  assign idx      = addr_i >> offset_lp;
  assign in_range = (idx < paddr_width_p'(els_p));
  assign mem_idx  = idx[idx_w_lp-1:0];

  // ready_en_q keeps ready_o low until the first edge after reset release.
  assign ready_o = ready_en_q & (count_q < cnt_w_lp'(outstanding_p)) & ~stall;
  assign accept  = v_i & ready_o;
  assign pop     = v_o & yumi_i;

  always_ff @(posedge clk_i) begin
    if (accept & w_i & in_range) begin
      for (int unsigned b = 0; b < mask_w_lp; b++) begin
        if (write_mask_i[b]) mem_q[mem_idx][b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end
  end

  // Read data is captured at accept so later writes cannot disturb it.
  always_comb begin
    req_entry = '0;
    if (!w_i && in_range) req_entry.data = mem_q[mem_idx];
  end

  always_comb begin
    count_d = count_q + cnt_w_lp'(accept) - cnt_w_lp'(pop);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

`ifdef BP_MEM_LATENCY_RAM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & lfsr_taps_gp)};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= lfsr_seed_gp;
    else            lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  bp_mem_ram_delay_pipe #(
    .latency_p (latency_p)
  ) delay_pipe (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (accept),
    .data_i    (req_entry),
    .v_o       (pipe_v),
    .data_o    (pipe_entry)
  );

  // Credit bound equals queue depth, so the pipe can always push.
  bp_mem_ram_fifo #(
    .width_p (entry_w_lp),
    .els_p   (outstanding_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (pipe_v),
    .data_i    (pipe_entry),
    .full_o    (fifo_full),
    .v_o       (fifo_v),
    .data_o    (head_entry),
    .yumi_i    (pop)
  );

  assign v_o    = fifo_v;
  assign data_o = fifo_v ? head_entry.data : '0;

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !v_o));

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(pipe_v && fifo_full));

endmodule

// File: tb/tb_bp_mem_latency_ram.sv
module tb_bp_mem_latency_ram;

  localparam int unsigned BW  = 512;
  localparam int unsigned MW  = BW / 8;
  localparam int unsigned ELS = 1024;
  localparam int unsigned LAT = 4;
  localparam int unsigned OUT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          v_i, w_i, yumi_i;
  logic [39:0]   addr_i;
  logic [BW-1:0] data_i;
  logic [MW-1:0] mask_i;
  logic          ready_o, v_o;
  logic [BW-1:0] data_o;

  always #5 clk = ~clk;

  bp_mem_latency_ram #(
    .block_width_p (BW),
    .paddr_width_p (40),
    .els_p         (ELS),
    .latency_p     (LAT),
    .outstanding_p (OUT)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .v_i          (v_i),
    .w_i          (w_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .write_mask_i (mask_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i)
  );

  // Reference model: block array plus a list of expected responses, each with
  // the earliest cycle it may appear.
  typedef struct { logic [BW-1:0] data; int unsigned elig; } exp_t;
  typedef struct { logic [BW-1:0] data; int unsigned edge_n; } got_t;

  logic [BW-1:0] ref_mem [ELS];
  exp_t          q[$];
  got_t          got[$];
  int unsigned   edges, last_acc, n_checks, n_pass, ready_low;
  logic          acc;

  task automatic check_eq(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < BW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: check outputs at negedge, drive, then update model at posedge.
  task automatic cyc(input logic v, input logic w, input logic [39:0] a,
                     input logic [BW-1:0] d, input logic [MW-1:0] m, input logic y);
    logic          exp_v, rdy, vo;
    logic [39:0]   idx;
    logic [BW-1:0] rd;
    @(negedge clk);
    exp_v = (q.size() != 0) && (q[0].elig <= edges);
    check_eq("v_o", v_o, exp_v);
    if (exp_v) check_eq("data_o", data_o, q[0].data);
`ifdef BP_MEM_LATENCY_RAM_BACKPRESSURE_EN
    check_eq("ready_credit", ready_o && (q.size() >= OUT), 1'b0);
    if (!ready_o) ready_low++;
`else
    check_eq("ready_o", ready_o, q.size() < OUT);
`endif
    rdy = ready_o;
    vo  = v_o;
    v_i = v; w_i = w; addr_i = a; data_i = d; mask_i = m;
    yumi_i = y & vo;
    if (yumi_i) got.push_back('{data_o, edges});
    @(posedge clk);
    edges++;
    acc = v && rdy;
    if (yumi_i && q.size() != 0) void'(q.pop_front());
    if (acc) begin
      idx = a >> 6;
      if (w || idx >= ELS) rd = '0;
      else                 rd = ref_mem[idx];
      if (w && idx < ELS)
        for (int b = 0; b < MW; b++) if (m[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      q.push_back('{rd, edges + LAT});
      last_acc = edges;
    end
    #1;
    v_i = 1'b0; w_i = 1'b0; yumi_i = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [39:0] a, input logic [BW-1:0] d,
                       input logic [MW-1:0] m, input logic y);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, w, a, d, m, y);
      if (acc) break;
    end
    if (!acc) check_eq("issue_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic y);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, y);
  endtask

  initial begin
    logic [BW-1:0] pat, saved;
    int unsigned   acc_r, accepted, cycles, ridx;
    logic [39:0]   a;

    n_checks = 0; n_pass = 0; edges = 0; ready_low = 0;
    reset_n = 1'b0; v_i = 0; w_i = 0; yumi_i = 0; addr_i = '0; data_i = '0; mask_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready_o, 1'b0);
    check_eq("rst_v", v_o, 1'b0);
    check_eq("rst_data", data_o, '0);
    reset_n = 1'b1;
    #1 check_eq("ready_before_edge", ready_o, 1'b0);
    @(posedge clk); #1;
`ifndef BP_MEM_LATENCY_RAM_BACKPRESSURE_EN
    check_eq("ready_after_edge", ready_o, 1'b1);
`endif

    // Fill every block so later reads are defined.
    for (int unsigned i = 0; i < ELS; i++) issue(1'b1, 40'(i) << 6, rand_blk(), '1, 1'b1);
    idle(8, 1'b1);

    // Write then read of the same block.
    pat = {4{128'h00112233445566778899AABBCCDDEEFF}};
    got.delete();
    issue(1'b1, 40'h40, pat, '1, 1'b0);
    issue(1'b0, 40'h40, '0, '0, 1'b0);
    acc_r = last_acc;
    idle(10, 1'b1);
    check_eq("wr_rd_count", got.size(), 2);
    if (got.size() >= 2) begin
      check_eq("wr_resp_zero", got[0].data, '0);
      check_eq("rd_data", got[1].data, pat);
      check_eq("rd_latency", got[1].edge_n - acc_r, LAT);
    end

    // Partial mask write.
    got.delete();
    issue(1'b1, 40'h80, {MW{8'hAA}}, '1, 1'b1);
    issue(1'b1, 40'h80, {MW{8'h55}}, 64'hF, 1'b1);
    issue(1'b0, 40'h80, '0, '0, 1'b1);
    idle(10, 1'b1);
    check_eq("pmask_count", got.size(), 3);
    if (got.size() >= 3) check_eq("pmask_data", got[2].data, {{(MW-4){8'hAA}}, {4{8'h55}}});

`ifndef BP_MEM_LATENCY_RAM_BACKPRESSURE_EN
    // Credit limit with no consumption.
    got.delete();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 40'(i) << 6, '0, '0, 1'b0);
      check_eq($sformatf("credit_acc%0d", i), acc, i < 4);
    end
    idle(3, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
    cyc(1'b1, 1'b0, 40'(4) << 6, '0, '0, 1'b0);
    check_eq("credit_5th_acc", acc, 1'b1);
    idle(12, 1'b1);
    check_eq("credit_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check_eq($sformatf("credit_order%0d", i), got[i].data, ref_mem[i]);
`endif

    // Out-of-range address.
    got.delete();
    saved = ref_mem[0];
    issue(1'b1, 40'(ELS) << 6, {MW{8'hFF}}, '1, 1'b1);
    issue(1'b0, 40'(ELS) << 6, '0, '0, 1'b1);
    issue(1'b0, 40'h0, '0, '0, 1'b1);
    idle(10, 1'b1);
    check_eq("oor_count", got.size(), 3);
    if (got.size() >= 3) begin
      check_eq("oor_rd_zero", got[1].data, '0);
      check_eq("oor_mem0", got[2].data, saved);
    end

    // Reset while requests are in flight.
    for (int i = 0; i < 3; i++) issue(1'b0, 40'(i + 8) << 6, '0, '0, 1'b0);
    idle(4, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_v", v_o, 1'b0);
    check_eq("midrst_ready", ready_o, 1'b0);
    check_eq("midrst_data", data_o, '0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    idle(8, 1'b1);

    // Randomized traffic against the model.
    accepted = 0; cycles = 0; ready_low = 0;
    while (accepted < 1000 && cycles < 20000) begin
      ridx = $urandom_range(0, ELS + 40);
      a = (40'(ridx) << 6) | 40'($urandom_range(0, 63));
      cyc($urandom_range(0, 99) < 75, $urandom_range(0, 2) == 0, a, rand_blk(),
          {$urandom, $urandom}, $urandom_range(0, 9) < 7);
      if (acc) accepted++;
      cycles++;
    end
    check_eq("random_done", accepted >= 1000, 1'b1);
    idle(20, 1'b1);
`ifdef BP_MEM_LATENCY_RAM_BACKPRESSURE_EN
    check_eq("bp_stall_rate", ready_low * 8 >= cycles, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_mem_latency_ram.md
Name: bp_mem_latency_ram

Overview:
- Block-granular test memory that sits directly downstream of the memory transducer in the ME testbenches.
- Consumes its ready/valid, write-masked block requests and returns one full-block response per request after a fixed, parameterized latency.
- Provides a cycle-accurate DRAM stand-in so CCE/transducer flow control is exercised under real backpressure.

Parameters:
- block_width_p, 512, data block width in bits; must be a multiple of 8.
- paddr_width_p, 40, request address width.
- els_p, 1024, number of blocks stored.
- latency_p, 4, cycles from request accept to earliest response valid; must be >= 1.
- outstanding_p, 4, maximum requests in flight (accepted but not yet yumi'd).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  request valid.
- w_i  in  1  request is a write.
- addr_i  in  paddr_width_p  block-aligned byte address; low log2(block_width_p/8) bits ignored.
- data_i  in  block_width_p  write data.
- write_mask_i  in  block_width_p/8  per-byte write enable.
- ready_o  out  1  request may be accepted this cycle.
- data_o  out  block_width_p  response data.
- v_o  out  1  response valid.
- yumi_i  in  1  response consumed; only legal while v_o=1.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (reset_n_i=0): ready_o=0 during reset; v_o=0; data_o=0; in-flight count=0; delay pipe and response queue emptied; LFSR reseeded. Storage array is not cleared.
- Reset asserted mid-operation discards all in-flight responses immediately. ready_o returns to 1 on the first clock edge after deassertion.
- Accept: accept = v_i & ready_o. ready_o = (count < outstanding_p), registered-state only; no combinational path from v_i or yumi_i.
- When count == outstanding_p, a same-cycle yumi_i does not make ready_o high that cycle.
- Index: idx = addr_i >> log2(block_width_p/8).
  - idx >= els_p: write ignored; read returns all zeros.
  - Otherwise the request is in range.
- Write on accept: byte b of mem[idx] is updated iff write_mask_i[b]. The update is visible to any request accepted on a later cycle.
  - The response data for a write is all zeros.
- Read on accept: mem[idx] is sampled at the accept edge and carried with the request. A later write never alters an already-accepted read.
- Latency: a request accepted at edge t is eligible as a response at edge t+latency_p. v_o rises in that cycle if all older responses have drained.
- Ordering: strict in-order; responses leave in accept order.
- Response queue: depth outstanding_p, fed by the delay pipe. v_o = queue not empty; data_o = queue head.
- Each cycle with v_o & yumi_i pops the head and decrements count. An accept increments count. A simultaneous accept and pop leaves count unchanged.
- Queue overflow is impossible by construction, since the credit bound equals the queue depth. Assert this in simulation.
- yumi_i with v_o=0 is an error; flag with an assertion. The block ignores it.
- Counter width: clog2(outstanding_p+1); never wraps.

Optional Feature:
- Macro: BP_MEM_LATENCY_RAM_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. ready_o is additionally forced low when lfsr[1:0]==2'b00, which injects pseudo-random stalls. Latency and ordering rules are otherwise unchanged.
- Undefined: no LFSR is instantiated; ready_o depends only on count.

Decomposition:
- Shared package bp_me_pkg holds:
  - the LFSR seed and tap constant;
  - a packed typedef for the in-flight entry {data}, used by both the delay pipe and the queue.
- Sub-module bp_mem_ram_delay_pipe: a latency_p-deep valid+data shift pipe with asynchronous active-low reset.
- The response queue reuses the existing small two-port FIFO primitive.
- Top level holds the storage array, indexing, credit counter and optional LFSR.

Test Plan:
- Write then read: write addr 0x40, data 0x1122..FF, full mask; accept read of 0x40 the next cycle -> read response v_o exactly latency_p=4 cycles after its accept, data 0x1122..FF. Write response data = 0.
- Partial mask: mem[2] preloaded with all 0xAA; write addr 0x80, mask 0x...000F, data all 0x55 -> subsequent read returns bytes 0-3 = 0x55, rest 0xAA.
- Credit limit: hold yumi_i=0 and issue 5 back-to-back reads -> 4 accepted, ready_o=0 on 5th cycle. Pulse yumi_i once -> ready_o=1 next cycle, 5th accepted, in-order data.
- Out-of-range: read addr = els_p*64 -> v_o after 4 cycles with data 0. Prior write to the same addr has no effect on mem[0].
- Reset mid-flight: 3 reads in flight, pull reset_n_i low asynchronously between edges -> v_o=0 immediately. After release, count=0, ready_o=1, no stale responses.
- Backpressure build (BP_MEM_LATENCY_RAM_BACKPRESSURE_EN): 1000 random requests against a scoreboard -> ready_o observed low at least once per ~4 cycles on average; all responses correct and in order.
